// File: rtl/mpc_constraint_fill_pkg.sv
// Shared types and constants for the constraint-vector fill engine.
// Modes, FSM states, the default Q16.16 bound and 32-bit saturation limits.
package mpc_fill_pkg;

    typedef enum logic [1:0] {
        CONST     = 2'd0,
        CYCLE     = 2'd1,
        NEG_CYCLE = 2'd2,
        RSVD      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MPC_DATA_W = 32;

    // 10.0 in Q16.16
    localparam logic [31:0] MPC_BOUND_DEFAULT = 32'd655360;

    localparam logic [MPC_DATA_W-1:0] MPC_SAT_MAX = {1'b0, {(MPC_DATA_W-1){1'b1}}};
    localparam logic [MPC_DATA_W-1:0] MPC_SAT_MIN = {1'b1, {(MPC_DATA_W-1){1'b0}}};

endpackage

// File: rtl/mpc_constraint_fill_if.sv
// Block-level ap_* handshake, fill configuration and RAM write port of the fill engine.
// master = controller side, slave = fill engine.
interface mpc_constraint_fill_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 4
);
    logic                    ap_start;
    logic                    ap_done;
    logic                    ap_idle;
    logic                    ap_ready;
    logic [ADDR_W-1:0]       cfg_base;
    logic [ADDR_W:0]         cfg_len;
    logic [1:0]              cfg_mode;
    logic [NCH*DATA_W-1:0]   bound_i;
    logic [ADDR_W-1:0]       h_address0;
    logic                    h_ce0;
    logic                    h_we0;
    logic [DATA_W-1:0]       h_d0;

    modport master (
        output ap_start, cfg_base, cfg_len, cfg_mode, bound_i,
        input  ap_done, ap_idle, ap_ready, h_address0, h_ce0, h_we0, h_d0
    );

    modport slave (
        input  ap_start, cfg_base, cfg_len, cfg_mode, bound_i,
        output ap_done, ap_idle, ap_ready, h_address0, h_ce0, h_we0, h_d0
    );

endinterface

// File: rtl/mpc_constraint_fill_value_sel.sv
// Combinational word generator: NCH-way channel select plus optional saturating negate.
// The negator exists only when MPC_CONSTRAINT_FILL_NEG_EN is defined; otherwise mode 2 acts as CYCLE.
module mpc_fill_value_sel
    import mpc_fill_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NCH    = 4,
    parameter int CH_W   = $clog2(NCH)
) (
    input  logic [NCH*DATA_W-1:0] bound_vec,
    input  logic [CH_W-1:0]       chan,
    input  mode_e                 mode,
    output logic [DATA_W-1:0]     value
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] ch_word [NCH];
    logic [DATA_W-1:0] picked;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign ch_word[gi] = bound_vec[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        picked = (mode == CONST) ? ch_word[0] : ch_word[chan];
        value  = picked;
`ifdef MPC_CONSTRAINT_FILL_NEG_EN
        // -MIN is not representable, so it clamps to MAX
        if (mode == NEG_CYCLE) begin
            value = (picked == SAT_MIN) ? SAT_MAX : ({DATA_W{1'b0}} - picked);
        end
`endif
    end

endmodule

// File: rtl/mpc_constraint_fill.sv
// Constraint-vector fill engine: writes cfg_len words from cfg_base, one per cycle, under ap_* control.
// Optional feature macro: MPC_CONSTRAINT_FILL_NEG_EN (saturating NEG_CYCLE mode).
module mpc_constraint_fill
    import mpc_fill_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 4
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    mpc_constraint_fill_if.slave bus
);

    localparam int CH_W = $clog2(NCH);

    state_e                state_reg, state_next;
    logic [ADDR_W-1:0]     addr_reg;
    logic [ADDR_W:0]       len_reg;
    logic [ADDR_W:0]       idx_reg;
    mode_e                 mode_reg;
    logic [NCH*DATA_W-1:0] bound_reg;
    logic [CH_W-1:0]       chan_reg;
    logic [DATA_W-1:0]     data_reg;

    mode_e                 cfg_mode_e;
    logic                  accept;
    logic                  start_zero;
    logic                  last_word;
    logic [NCH*DATA_W-1:0] sel_bounds;
    logic [CH_W-1:0]       sel_chan;
    mode_e                 sel_mode;
    logic [DATA_W-1:0]     sel_value;

    assign cfg_mode_e = mode_e'(bus.cfg_mode);
    assign accept     = (state_reg == IDLE) && bus.ap_start;
    assign start_zero = (bus.cfg_len == '0) || (cfg_mode_e == RSVD);
    assign last_word  = (idx_reg + 1'b1) == len_reg;

    // In IDLE the first word comes straight from the live inputs so it is
    // registered together with the accept; in RUN the next word is prefetched.
    assign sel_bounds = (state_reg == IDLE) ? bus.bound_i : bound_reg;
    assign sel_chan   = (state_reg == IDLE) ? '0 : chan_reg + 1'b1;
    assign sel_mode   = (state_reg == IDLE) ? cfg_mode_e : mode_reg;

    mpc_fill_value_sel #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .CH_W   (CH_W)
    ) u_value_sel (
        .bound_vec (sel_bounds),
        .chan      (sel_chan),
        .mode      (sel_mode),
        .value     (sel_value)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.ap_start) state_next = start_zero ? DONE : RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            addr_reg  <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            mode_reg  <= CONST;
            bound_reg <= '0;
            chan_reg  <= '0;
            data_reg  <= '0;
        end else if (accept) begin
            len_reg   <= bus.cfg_len;
            mode_reg  <= cfg_mode_e;
            bound_reg <= bus.bound_i;
            idx_reg   <= '0;
            chan_reg  <= '0;
            // Zero-length runs leave the RAM port values untouched
            if (!start_zero) begin
                addr_reg <= bus.cfg_base;
                data_reg <= sel_value;
            end
        end else if ((state_reg == RUN) && !last_word) begin
            idx_reg  <= idx_reg + 1'b1;
            chan_reg <= chan_reg + 1'b1;
            addr_reg <= addr_reg + 1'b1;
            data_reg <= sel_value;
        end
    end

    assign bus.ap_idle    = (state_reg == IDLE);
    assign bus.ap_done    = (state_reg == DONE);
    assign bus.ap_ready   = accept && !ap_rst;
    assign bus.h_ce0      = (state_reg == RUN);
    assign bus.h_we0      = (state_reg == RUN);
    assign bus.h_address0 = addr_reg;
    assign bus.h_d0       = data_reg;

endmodule
